// File: rtl/cvtsw_seq.sv
// cvt.s.w: signed 32-bit integer to binary32, shift-loop normalizer.
// Define CVTSW_RNE_EN for round-to-nearest-even; default truncates.
module cvtsw_seq #(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_inexact
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        OUT
    } state_t;

    state_t      state;
    logic        sign;
    logic [31:0] m;
    logic [7:0]  exp;

    logic [31:0] mag;
    logic [22:0] frac;
    logic        guard;
    logic        sticky;
    logic        inexact;
    logic        top_zero;
    logic [30:0] packed_mag;

    always_comb begin
        mag      = in_data[31] ? (~in_data + 32'd1) : in_data;
        frac     = m[30:8];
        guard    = m[7];
        sticky   = |m[6:0];
        inexact  = guard | sticky;
        top_zero = (m[31 -: SHIFT_STEP] == '0);
`ifdef CVTSW_RNE_EN
        // A carry out of frac lands in exp, which is the overflow bump.
        packed_mag = {exp, frac}
                   + {30'd0, guard & (sticky | frac[0])};
`else
        packed_mag = {exp, frac};
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 32'd0;
            out_inexact <= 1'b0;
            sign        <= 1'b0;
            m           <= 32'd0;
            exp         <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        sign     <= in_data[31];
                        m        <= mag;
                        exp      <= 8'd158;
                        if (in_data == 32'd0) begin
                            out_data    <= 32'd0;
                            out_inexact <= 1'b0;
                            state       <= OUT;
                        end else begin
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (m[31]) begin
                        out_data    <= {sign, packed_mag};
                        out_inexact <= inexact;
                        state       <= OUT;
                    end else if (top_zero) begin
                        m   <= m << SHIFT_STEP;
                        exp <= exp - 8'(SHIFT_STEP);
                    end else begin
                        m   <= m << 1;
                        exp <= exp - 8'd1;
                    end
                end
                OUT: begin
                    // Result registers settle one cycle before out_valid.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cvtsw_seq.md
Name: cvtsw_seq

Overview:
- Multi-cycle signed-word to single-precision float converter (FPU cvt.s.w path); the inverse of the FPU's float-to-word converter.
- Accepts a 32-bit two's-complement integer over a valid/ready handshake.
- Normalizes the magnitude with a shift loop, rounds, and presents an IEEE-754 binary32 result over a second valid/ready handshake.
- Sits beside the other FPU conversion units; the issue logic stalls on in_ready.

Parameters:
- SHIFT_STEP, 1, leading-zero positions the normalizer may skip per cycle; legal values 1, 2, 4, 8.

Ports:
- clk  input  1  clock; all state changes on rising edge
- resetn  input  1  asynchronous active-low reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept an operand
- in_data  input  32  signed integer operand
- out_valid  output  1  out_data/out_inexact are valid
- out_ready  input  1  consumer accepts the result
- out_data  output  32  binary32 result {sign, exp[7:0], frac[22:0]}
- out_inexact  output  1  result differs from the exact integer value

Behaviour:
- Reset (async, resetn=0), all cleared immediately, whatever the state:
  - state=IDLE; in_ready=0 while reset asserted, 1 from first clk edge after release.
  - out_valid=0, out_data=0, out_inexact=0.
  - An in-flight conversion is discarded.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready:
    - capture sign=in_data[31] and m=|in_data| as 32-bit unsigned (-2^31 gives m=0x80000000);
    - set exp=158 (127+31);
    - if in_data==0, go to OUT with out_data=0x00000000, out_inexact=0;
    - else go to NORM.
  - NORM: each cycle:
    - if m[31]=1, pack and go to OUT;
    - else if the top SHIFT_STEP bits of m are all zero, m<<=SHIFT_STEP and exp-=SHIFT_STEP;
    - else m<<=1 and exp-=1.
  - OUT: out_valid=1; out_data and out_inexact held stable until out_valid&out_ready, then go to IDLE.
- Packing (combinational in the final NORM cycle, registered into the out_* registers):
  - frac=m[30:8], guard=m[7], sticky=|m[6:0]; out_inexact=guard|sticky.
  - Truncation (default): out_data={sign, exp, frac}.
- Latency, with handshake at edge T and N shift cycles:
  - out_valid rises after edge T+N+2; zero input rises after edge T+1.
  - SHIFT_STEP=1 gives N = number of leading zeros of m.
- Throughput:
  - one conversion in flight; in_ready=0 in NORM and OUT;
  - in_ready returns the cycle after the output handshake (no same-cycle bypass).
- in_data is sampled only at the input handshake; later changes are ignored.
- The result is always normal or zero; no NaN/Inf/denormal is produced.
- exp is 8 bits and never underflows, since minimum exp is 127 for |x|=1.

Optional Feature:
- Macro CVTSW_RNE_EN.
- Defined: round-to-nearest-even.
  - Increment frac if guard & (sticky | frac[0]).
  - If frac overflows (all ones + 1), frac=0 and exp+=1.
  - Rounding adds no cycles.
- Undefined: truncation toward zero, as in Packing. out_inexact is identical in both builds.

Test Plan:
- SHIFT_STEP=1, in_data=1 -> out_data=0x3F800000, out_inexact=0, out_valid after edge T+33. in_data=-1 -> 0xBF800000.
- in_data=0 -> 0x00000000 after edge T+1. in_data=0x80000000 (-2^31) -> 0xCF000000, inexact=0, out_valid after edge T+2.
- in_data=16777219 -> truncate build 0x4B800001, RNE build 0x4B800002, out_inexact=1 in both.
- in_data=2147483647 -> truncate 0x4EFFFFFF; RNE 0x4F000000 (frac overflow, exponent bump); out_inexact=1.
- Backpressure:
  - hold out_ready=0 for 10 cycles: out_valid and out_data stable, in_ready=0, a new in_valid is not accepted;
  - release: in_ready=1 one cycle after the output handshake.
- Pulse resetn=0 mid-NORM -> out_valid=0 and state IDLE immediately. A following conversion of 5 -> 0x40A00000.
